// File: rtl/uart_tx_word_feeder.sv
// Feeds one multi-byte word to a UART transmitter a byte at a time, with an optional sync header.
// Each next byte is paced by the rising edge of the transmitter's DONE.
module uart_tx_word_feeder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    WORD_BYTES  = 4,
  parameter int                    MSB_FIRST   = 1,
  parameter int                    HEADER_EN   = 1,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                             CLK100MHZ,
  input  logic                             RESET,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] IN_DATA,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  output logic                             TX_EN,
  output logic [DATA_WIDTH-1:0]            TX_DATA,
  input  logic                             TX_DONE,
  output logic                             BUSY,
  output logic                             WORD_DONE
);

  localparam int         HDR      = (HEADER_EN != 0) ? 1 : 0;
  localparam int         N_BYTES  = WORD_BYTES + HDR;
  localparam int         WORD_W   = WORD_BYTES * DATA_WIDTH;
  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                  r_state;
  logic [3:0]              r_idx;
  logic                    r_done_q;
  logic [WORD_W-1:0]       r_word;
  logic                    r_tx_en;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_busy;
  logic                    r_word_done;

  logic [DATA_WIDTH-1:0]   w_seq [16];
  logic [DATA_WIDTH-1:0]   w_first_byte;
  logic [3:0]              w_next_idx;
  logic                    w_done_rise;

  // Transmit order of the latched word: header (if any) followed by payload bytes.
  for (genvar gi = 0; gi < 16; gi++) begin : g_seq
    if (HDR == 1 && gi == 0) begin : g_hdr
      assign w_seq[gi] = HEADER_BYTE;
    end else if (gi < N_BYTES) begin : g_pay
      localparam int K   = gi - HDR;
      localparam int OFS = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - K) * DATA_WIDTH : K * DATA_WIDTH;
      assign w_seq[gi] = r_word[OFS +: DATA_WIDTH];
    end else begin : g_unused
      assign w_seq[gi] = '0;
    end
  end

  // Byte 0 is taken straight from the input so TX_DATA is valid on the accepting edge.
  if (HDR == 1) begin : g_first_hdr
    assign w_first_byte = HEADER_BYTE;
  end else if (MSB_FIRST != 0) begin : g_first_msb
    assign w_first_byte = IN_DATA[(WORD_BYTES-1)*DATA_WIDTH +: DATA_WIDTH];
  end else begin : g_first_lsb
    assign w_first_byte = IN_DATA[DATA_WIDTH-1:0];
  end

  assign w_next_idx  = r_idx + 4'd1;
  // DONE stays high between words, so only its rising edge counts as a completion.
  assign w_done_rise = TX_DONE & ~r_done_q;

  assign IN_READY  = (r_state == ST_IDLE);
  assign TX_EN     = r_tx_en;
  assign TX_DATA   = r_tx_data;
  assign BUSY      = r_busy;
  assign WORD_DONE = r_word_done;

  always_ff @(posedge CLK100MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_done_q    <= 1'b0;
      r_word      <= '0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_done_q    <= TX_DONE;
      r_word_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_word    <= IN_DATA;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_tx_en   <= 1'b1;
            r_tx_data <= w_first_byte;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_done_rise) begin
            if (r_idx == LAST_IDX) begin
              r_tx_en     <= 1'b0;
              r_busy      <= 1'b0;
              r_word_done <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_seq[w_next_idx];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Bench for uart_tx_word_feeder: three parameterisations, each paired with a behavioural
// UART transmitter that records every byte it latches and holds DONE high after a frame.
module tb_uart_tx_word_feeder;

  localparam int FRAME_CYC = 40;  // 10 bits x baud_count 4

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data [3] = '{32'h0, 32'h0, 32'h0};
  logic        in_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic        in_ready [3];
  logic        tx_en [3];
  logic [7:0]  tx_data [3];
  logic        tx_done [3];
  logic        busy [3];
  logic        word_done [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_word_feeder u_dut0 (
    .CLK100MHZ(clk), .RESET(rst_n), .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]),
    .IN_READY(in_ready[0]), .TX_EN(tx_en[0]), .TX_DATA(tx_data[0]), .TX_DONE(tx_done[0]),
    .BUSY(busy[0]), .WORD_DONE(word_done[0]));

  uart_tx_word_feeder #(.MSB_FIRST(0), .HEADER_EN(0)) u_dut1 (
    .CLK100MHZ(clk), .RESET(rst_n), .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]),
    .IN_READY(in_ready[1]), .TX_EN(tx_en[1]), .TX_DATA(tx_data[1]), .TX_DONE(tx_done[1]),
    .BUSY(busy[1]), .WORD_DONE(word_done[1]));

  uart_tx_word_feeder #(.WORD_BYTES(1), .HEADER_EN(0)) u_dut2 (
    .CLK100MHZ(clk), .RESET(rst_n), .IN_DATA(in_data[2][7:0]), .IN_VALID(in_valid[2]),
    .IN_READY(in_ready[2]), .TX_EN(tx_en[2]), .TX_DATA(tx_data[2]), .TX_DONE(tx_done[2]),
    .BUSY(busy[2]), .WORD_DONE(word_done[2]));

  // Transmitter model: IDLE -> START (latch DATA) -> SHIFT -> END (DONE=1) -> IDLE.
  // DONE only drops when TXEN starts a new frame.
  int         tx_st [3];
  int         tx_cnt [3];
  logic [7:0] cap [3][64];
  int         cap_n [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        tx_st[c]   <= 0;
        tx_cnt[c]  <= 0;
        tx_done[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        case (tx_st[c])
          0: if (tx_en[c]) begin
               tx_st[c]   <= 1;
               tx_done[c] <= 1'b0;
             end
          1: begin
               if (cap_n[c] < 64) cap[c][cap_n[c]] <= tx_data[c];
               cap_n[c]  <= cap_n[c] + 1;
               tx_cnt[c] <= FRAME_CYC - 1;
               tx_st[c]  <= 2;
             end
          2: if (tx_cnt[c] == 0) begin
               tx_st[c]   <= 3;
               tx_done[c] <= 1'b1;
             end else begin
               tx_cnt[c] <= tx_cnt[c] - 1;
             end
          default: tx_st[c] <= 0;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // WORD_DONE monitor: one-cycle pulse, exactly one cycle after the DONE rise.
  int   cyc = 0;
  int   rise_cyc [3] = '{0, 0, 0};
  int   wd_cnt [3] = '{0, 0, 0};
  logic prev_done [3] = '{1'b0, 1'b0, 1'b0};
  logic prev_wd [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 3; c++) begin
      if (tx_done[c] === 1'b1 && prev_done[c] !== 1'b1) rise_cyc[c] = cyc;
      if (word_done[c] === 1'b1) begin
        wd_cnt[c]++;
        check($sformatf("wd_latency_ch%0d", c), 32'(cyc - rise_cyc[c]), 32'd1);
        check($sformatf("wd_one_cycle_ch%0d", c), 32'(prev_wd[c]), 32'd0);
      end
      prev_done[c] = tx_done[c];
      prev_wd[c]   = word_done[c];
    end
  end

  task automatic send_word(input int c, input logic [31:0] d);
    check($sformatf("ready_before_ch%0d", c), 32'(in_ready[c]), 32'd1);
    in_data[c]  = d;
    in_valid[c] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic wait_word_done(input int c, input int start_cnt);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      #1;
      if (wd_cnt[c] != start_cnt) break;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL wd_timeout_ch%0d: got no WORD_DONE expected one within 3000 cycles", c);
    end
  endtask

  task automatic check_frames(input string name, input int c, input int base,
                              input logic [7:0] exp [], input int n);
    check({name, "_nframes"}, 32'(cap_n[c] - base), 32'(n));
    for (int k = 0; k < n; k++)
      if (base + k < 64)
        check($sformatf("%s_byte%0d", name, k), 32'(cap[c][base + k]), 32'(exp[k]));
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          n;
    logic [7:0]  exp [5];
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input int ch, input logic [31:0] d, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    vecs[i].ch = ch; vecs[i].data = d; vecs[i].n = n;
    vecs[i].exp[0] = b0; vecs[i].exp[1] = b1; vecs[i].exp[2] = b2;
    vecs[i].exp[3] = b3; vecs[i].exp[4] = b4;
  endtask

  initial begin
    logic [7:0] exp_dyn [];
    int base;
    int wd0;
    int t;

    set_vec(0, 0, 32'h11223344, 5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44);
    set_vec(1, 1, 32'h11223344, 4, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00);
    set_vec(2, 0, 32'h00FF807F, 5, 8'hA5, 8'h00, 8'hFF, 8'h80, 8'h7F);
    set_vec(3, 1, 32'hA1B2C3D4, 4, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00);
    set_vec(4, 2, 32'h00000000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(5, 2, 32'h0000005A, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst_ready_ch%0d", c), 32'(in_ready[c]), 32'd1);
      check($sformatf("rst_txen_ch%0d", c), 32'(tx_en[c]), 32'd0);
      check($sformatf("rst_busy_ch%0d", c), 32'(busy[c]), 32'd0);
      check($sformatf("rst_txdata_ch%0d", c), 32'(tx_data[c]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ready", 32'(in_ready[0]), 32'd1);

    // Single words across all three parameterisations.
    for (int i = 0; i < 6; i++) begin
      int c;
      c = vecs[i].ch;
      base = cap_n[c];
      wd0 = wd_cnt[c];
      send_word(c, vecs[i].data);
      wait_word_done(c, wd0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_ready_after", i), 32'(in_ready[c]), 32'd1);
      check($sformatf("v%0d_txen_after", i), 32'(tx_en[c]), 32'd0);
      check($sformatf("v%0d_wd_count", i), 32'(wd_cnt[c] - wd0), 32'd1);
      exp_dyn = new[5];
      for (int k = 0; k < 5; k++) exp_dyn[k] = vecs[i].exp[k];
      check_frames($sformatf("v%0d", i), c, base, exp_dyn, vecs[i].n);
    end

    // Back-to-back with IN_VALID held; data changes mid-word must not disturb the first word.
    base = cap_n[0];
    wd0 = wd_cnt[0];
    in_data[0] = 32'hDEADBEEF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_data[0] = 32'h01020304;
    wait_word_done(0, wd0);
    check("b2b_ready_at_wd", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    #1;
    check("b2b_accept_busy", 32'(busy[0]), 32'd1);
    check("b2b_accept_txdata", 32'(tx_data[0]), 32'hA5);
    in_valid[0] = 1'b0;
    wait_word_done(0, wd0 + 1);
    @(negedge clk);
    exp_dyn = new[10];
    exp_dyn = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    check_frames("b2b", 0, base, exp_dyn, 10);

    // IN_DATA rewritten to all-ones while the first word is in flight.
    base = cap_n[1];
    wd0 = wd_cnt[1];
    in_data[1] = 32'h11223344;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    in_data[1] = 32'hFFFFFFFF;
    wait_word_done(1, wd0);
    @(negedge clk);
    #1;
    in_valid[1] = 1'b0;
    wait_word_done(1, wd0 + 1);
    @(negedge clk);
    exp_dyn = new[8];
    exp_dyn = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_frames("chg", 1, base, exp_dyn, 8);

    // Asynchronous reset during the third frame, then a clean word.
    base = cap_n[0];
    send_word(0, 32'h12345678);
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (cap_n[0] >= base + 3) break;
    end
    check("rst_mid_reach_frame3", 32'(cap_n[0] >= base + 3), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txen", 32'(tx_en[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_ready", 32'(in_ready[0]), 32'd1);
    check("rst_mid_txdata", 32'(tx_data[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_rel_txen", 32'(tx_en[0]), 32'd0);
    check("rst_rel_busy", 32'(busy[0]), 32'd0);
    check("rst_rel_ready", 32'(in_ready[0]), 32'd1);
    base = cap_n[0];
    wd0 = wd_cnt[0];
    send_word(0, 32'hCAFEF00D);
    wait_word_done(0, wd0);
    @(negedge clk);
    exp_dyn = new[5];
    exp_dyn = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    check_frames("after_rst", 0, base, exp_dyn, 5);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_feeder.md
Name: uart_tx_word_feeder

Overview:
- Sits directly upstream of the UART transmitter and is the only driver of its TXEN and DATA inputs.
- Accepts one multi-byte word per valid/ready handshake from the design (e.g. DNN result words).
- Optionally prepends a sync header byte, then presents the bytes one at a time and paces them on the transmitter's DONE pulse.
- Reports completion of each word.

Parameters:
- DATA_WIDTH, 8: width of one UART byte; must equal the transmitter's DATA_WIDTH.
- WORD_BYTES, 4: number of payload bytes per input word (1..15).
- MSB_FIRST, 1: 1 = send the most significant byte first; 0 = send the least significant byte first.
- HEADER_EN, 1: 1 = send HEADER_BYTE before each word's payload.
- HEADER_BYTE, 8'hA5: value of the sync header byte.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz, all logic on the rising edge.
- RESET  input  1  asynchronous, active-low reset. The top level inverts it for the transmitter.
- IN_DATA  input  WORD_BYTES*DATA_WIDTH  word to transmit.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  the block accepts a word this cycle.
- TX_EN  output  1  drives the transmitter's TXEN.
- TX_DATA  output  DATA_WIDTH  drives the transmitter's DATA.
- TX_DONE  input  1  the transmitter's DONE.
- BUSY  output  1  a word is in flight.
- WORD_DONE  output  1  one-cycle pulse when the last byte of a word has completed.

Behaviour:
- Reset (RESET=0, asynchronous) sets: state=IDLE, TX_EN=0, TX_DATA=0, WORD_DONE=0, BUSY=0, byte index=0, done_q=0, word register=0.
- IN_READY is combinational: IN_READY = (state==IDLE). It is therefore 1 immediately after reset.
- N_BYTES = WORD_BYTES + HEADER_EN. The index register is 4 bits wide.
- done_rise = TX_DONE & ~done_q, where done_q is TX_DONE registered every cycle.
  - Use done_rise only; never the TX_DONE level.
  - The transmitter holds DONE high while TXEN is low after a frame, so the level is stale when a new word starts.
- IDLE:
  - BUSY=0, TX_EN=0.
  - On IN_VALID & IN_READY: latch IN_DATA, set index=0, BUSY<=1, and on the same edge set TX_EN<=1 and TX_DATA<=byte 0. Go to SEND.
  - Byte 0 is HEADER_BYTE if HEADER_EN=1, otherwise the first payload byte.
- SEND:
  - TX_EN is held at 1 and TX_DATA is held stable until done_rise.
  - On done_rise with index < N_BYTES-1: index<=index+1 and TX_DATA<=next byte on that same edge. TX_EN stays 1, with no gap cycle.
    - The transmitter leaves its end state on that edge and latches the new DATA on the following edge.
  - On done_rise with index == N_BYTES-1: TX_EN<=0, BUSY<=0, WORD_DONE<=1 for exactly one cycle, go to IDLE.
  - TX_DATA keeps its last value after the word ends.
- Payload byte order:
  - MSB_FIRST=1: payload byte k = IN_DATA[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH].
  - MSB_FIRST=0: payload byte k = IN_DATA[k*DATA_WIDTH +: DATA_WIDTH].
- Back-to-back words: the earliest next acceptance is the cycle after WORD_DONE, since IN_READY=1 in IDLE. IN_VALID held high is accepted that cycle.
- IN_VALID or IN_DATA changing while in SEND is ignored. The latched word is unaffected.
- A done_rise in IDLE is ignored.
- Reset mid-word: outputs return to reset values at once and the partial word is discarded. The transmitter must share the same reset.
- No timeout: if TX_DONE never rises, the block stays in SEND.

Test Plan (bench pairs the block with the real transmitter using baud_count=4; a UART monitor decodes TXD):
- Default parameters, IN_DATA=32'h11223344 with IN_VALID for 1 cycle -> TXD frames A5,11,22,33,44 in order. WORD_DONE pulses once, exactly 1 cycle after the 5th DONE rise; IN_READY=1 on the following cycle.
- MSB_FIRST=0, HEADER_EN=0, IN_DATA=32'h11223344 -> frames 44,33,22,11. No header frame is sent.
- Two words 32'hDEADBEEF then 32'h01020304 with IN_VALID held high -> 10 frames, second word accepted the cycle after the first WORD_DONE. During the second word's start (stale DONE still high) no byte is skipped and no byte is duplicated.
- IN_DATA changed to 32'hFFFFFFFF mid-word while IN_VALID=1 -> the current word's bytes are unchanged and the new value is sent only as the next word.
- RESET driven low during the 3rd frame -> TX_EN=0, BUSY=0, IN_READY=1 immediately after release. A new word 32'hCAFEF00D then sends A5,CA,FE,F0,0D cleanly.
- WORD_BYTES=1, HEADER_EN=0, IN_DATA=8'h00 -> exactly one frame with TXD data bits all 0, followed by one WORD_DONE pulse.
